// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encodings, 3-sample
//               majority vote and the tick-divider formula.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_data    = 3'd2;
    localparam logic [2:0] c_st_par     = 3'd3;
    localparam logic [2:0] c_st_stop    = 3'd4;
    localparam logic [2:0] c_st_deliver = 3'd5;
    localparam logic [2:0] c_st_brk     = 3'd6;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Rounded clk cycles per oversample tick, e.g. 16 MHz / (9600 * 16) -> 104.
    function automatic int calc_tick_div(input int clk_hz, input int baud, input int ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
// Module      : uart_tick_gen
// Description : Oversample tick divider; one-cycle strobe every TICK_DIV clks,
//               synchronously restartable so the phase follows a start edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tick_gen #(
    parameter int TICK_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_restart;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ovs.sv
// ============================================================================
// Module      : uart_rx_ovs
// Description : Oversampling UART receiver with majority-vote sampling, false
//               start rejection, framing/parity/overrun reporting and a
//               valid/ready output. Parity stage built only with the
//               UART_RX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ovs #(
    parameter int DATA_WIDTH = 8,
    parameter int OVS        = 16,
    parameter int TICK_DIV   = 104,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);

    import uart_pkg::*;

    localparam int c_smp_w = $clog2(OVS);
    localparam int c_bit_w = $clog2(DATA_WIDTH + 2);

    localparam logic [c_smp_w-1:0] c_smp_lo   = c_smp_w'(OVS / 2 - 1);
    localparam logic [c_smp_w-1:0] c_smp_mid  = c_smp_w'(OVS / 2);
    localparam logic [c_smp_w-1:0] c_smp_hi   = c_smp_w'(OVS / 2 + 1);
    localparam logic [c_smp_w-1:0] c_smp_last = c_smp_w'(OVS - 1);
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    logic                  r_rx_prev;
    logic [1:0]            r_flush;
    logic                  r_armed;
    logic [2:0]            r_state;
    logic [c_smp_w-1:0]    r_smp_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [1:0]            r_vote;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_frame_err_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic                  r_overrun;

    logic w_tick;
    logic w_edge;
    logic w_restart;
    logic w_vote;
    logic w_centre;

`ifdef UART_RX_PARITY_EN
    localparam logic c_parity_odd = 1'(PARITY_ODD);
    logic r_parity_err_nxt;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

    // The synchroniser resets to 1, so a line already low at release would
    // look like a falling edge; edges are ignored until a real high is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_flush   <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_flush   <= {r_flush[0], 1'b1};
            if (r_flush[1] && r_rx_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_edge    = r_armed && r_rx_prev && !r_rx_sync;
    assign w_restart = (r_state == c_st_idle) && w_edge;
    assign w_vote    = majority3({r_vote, r_rx_sync});
    assign w_centre  = w_tick && (r_smp_cnt == c_smp_hi);

    uart_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp_cnt <= '0;
            r_vote    <= 2'b11;
        end else if (w_restart) begin
            r_smp_cnt <= '0;
        end else if (w_tick) begin
            r_smp_cnt <= (r_smp_cnt == c_smp_last) ? '0 : r_smp_cnt + 1'b1;
            if (r_smp_cnt == c_smp_lo) begin
                r_vote[0] <= r_rx_sync;
            end
            if (r_smp_cnt == c_smp_mid) begin
                r_vote[1] <= r_rx_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_st_idle;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_frame_err_nxt <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err_nxt <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_edge) begin
                        r_state         <= c_st_start;
                        r_frame_err_nxt <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_parity_err_nxt <= 1'b0;
`endif
                    end
                end
                c_st_start: begin
                    if (w_centre) begin
                        r_bit_cnt <= '0;
                        r_state   <= w_vote ? c_st_idle : c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_centre) begin
                        r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= c_st_par;
`else
                            r_state   <= c_st_stop;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_st_par: begin
                    if (w_centre) begin
                        r_parity_err_nxt <= (^r_shift) ^ w_vote ^ c_parity_odd;
                        r_state          <= c_st_stop;
                    end
                end
`endif
                c_st_stop: begin
                    if (w_centre) begin
                        if (!w_vote) begin
                            r_frame_err_nxt <= 1'b1;
                        end
                        if (r_bit_cnt == c_stop_last) begin
                            r_state <= c_st_deliver;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_st_deliver: begin
                    r_state <= r_frame_err_nxt ? c_st_brk : c_st_idle;
                end
                c_st_brk: begin
                    if (r_rx_sync) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // A pending word is never overwritten; the new one is dropped instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_state == c_st_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data   <= r_shift;
                    r_frame_err <= r_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= r_parity_err_nxt;
`else
                    r_parity_err <= 1'b0;
`endif
                    r_rx_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
// ============================================================================
// Module      : tb_uart_rx_ovs
// Description : Scoreboard bench for uart_rx_ovs: directed and random frames,
//               expected words queued at send time and checked on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ovs;

    localparam int DW         = 8;
    localparam int OVS        = 16;
    localparam int TICK_DIV   = 4;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = OVS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 1 + DW + 1 + STOP_BITS;
`else
    localparam int FRAME_BITS = 1 + DW + STOP_BITS;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          rx       = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fe;
        logic          pe;
    } word_t;

    word_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_ovr = 0;

    uart_rx_ovs #(
        .DATA_WIDTH (DW),
        .OVS        (OVS),
        .TICK_DIV   (TICK_DIV),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Parity bit that makes the frame's parity correct for PARITY_ODD.
    function automatic logic good_pbit(input logic [DW-1:0] d);
        return (($countones(d) % 2) != PARITY_ODD);
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_val,
                              input logic pbit, input bit push);
        word_t e;
        e.data = d;
        e.fe   = (stop_val == 1'b0);
`ifdef UART_RX_PARITY_EN
        e.pe   = ((($countones(d) + int'(pbit)) % 2) != PARITY_ODD);
`else
        e.pe   = 1'b0 & pbit;
`endif
        if (push) exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_val);
    endtask

    // Scoreboard monitor: every accepted word must match the head of the queue.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (rst && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: actual data %0h, required no word", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                end
            end
            if (overrun) n_ovr++;
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: actual timeout, required end of test");
        $fatal(1, "bench timeout");
    end

    initial begin
        int     ov0;
        logic [DW-1:0] d;
        logic   stop_val;
        logic   pbit;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_rx_data", 32'(rx_data), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_parity_err", 32'(parity_err), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        idle(BIT_CLKS);

        // Clean frame
        send_frame(8'hA5, 1'b1, good_pbit(8'hA5), 1'b1);
        idle(BIT_CLKS);

        // 3-tick glitch is a false start
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_high", 32'(busy), 1);
        repeat (BIT_CLKS + 20) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_no_word", 32'(exp_q.size()), 0);

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, good_pbit(8'h3C), 1'b1);
        repeat (FRAME_BITS * BIT_CLKS) @(negedge clk);
        check("break_busy", 32'(busy), 1);
        repeat (FRAME_BITS * BIT_CLKS) @(negedge clk);
        idle(BIT_CLKS);
        check("break_released", 32'(busy), 0);
        send_frame(8'h55, 1'b1, good_pbit(8'h55), 1'b1);
        idle(BIT_CLKS);

        // Overrun: second word dropped while the first is pending
        @(posedge clk); #1 rx_ready = 1'b0;
        ov0 = n_ovr;
        send_frame(8'h11, 1'b1, good_pbit(8'h11), 1'b1);
        idle(20);
        send_frame(8'h22, 1'b1, good_pbit(8'h22), 1'b0);
        idle(20);
        check("ovr_valid_held", 32'(rx_valid), 1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_pulse_count", 32'(n_ovr - ov0), 1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 32'(rx_valid), 0);
        idle(BIT_CLKS);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(BIT_CLKS);
`endif

        // Reset mid-frame with the line low at release
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(rx_valid), 0);
        rst = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("midrst_no_frame", 32'(busy), 0);
        idle(BIT_CLKS);
        send_frame(8'h81, 1'b1, good_pbit(8'h81), 1'b1);
        idle(BIT_CLKS);

        // Random frames
        for (int n = 0; n < 24; n++) begin
            d        = DW'($urandom);
            stop_val = ($urandom_range(0, 5) != 0);
            pbit     = ($urandom_range(0, 3) == 0) ? ~good_pbit(d) : good_pbit(d);
            send_frame(d, stop_val, pbit, 1'b1);
            idle(stop_val ? $urandom_range(0, 40) : $urandom_range(8, 48));
        end

        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("total_overruns", 32'(n_ovr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
